alu_seq_control: RTL and testbench
==================================

# alu_seq_control

Hard-wired control sequencer for the Mini SRC datapath. It steps the shared bus/register datapath through instruction fetch (T0–T2) and execution (T3–T6) of ALU-class instructions, and asserts every bus-drive/register-load strobe that the datapath test benches currently drive by hand. The datapath top-level instantiates it in place of manual control signals. Only ALU, multiply/divide, nop and halt instructions are in scope; load, store and branch decode go to a later block.

## Interface
- OPW, 5, opcode width (IR[31:27])
- CNTW, 16, completed-instruction counter width

- Clock  in  1  system clock; all state changes on its rising edge
- Clear  in  1  asynchronous, active-high reset
- Stop  in  1  pause request, sampled only at instruction boundary
- mem_done  in  1  memory read complete; sampled in T1
- IR_opcode  in  OPW  IR[31:27] from the datapath IR
- PCout, MARin, IncPC, Read, MDRin, MDRout, IRin  out  1 each  fetch strobes
- Gra, Grb, Grc, Rin, Rout  out  1 each  register-select / general-register bus strobes
- Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin  out  1 each  ALU-path strobes
- alu_op  out  OPW  ALU operation select
- Run  out  1  1 while sequencing, 0 in IDLE/HALT
- illegal  out  1  sticky; set on unsupported opcode
- instr_count  out  CNTW  completed instructions, wraps

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT. Moore outputs, decoded from state register (and op_q); an unlisted strobe is 0.
- IDLE: Run=0. Goes to T0 when Stop=0; otherwise stays.
- T0: PCout, MARin, IncPC.
- T1: Read, MDRin. Stays in T1 while mem_done=0. Leaves on the edge where mem_done=1.
- T2: MDRout, IRin. On exit, op_q <= IR_opcode.
- Opcodes (5-bit):
  - binary: add 00011, sub 00100, shr 00101, shra 00110, shl 00111, ror 01000, rol 01001, and 01010, or 01011
  - mul 01111, div 10000
  - unary: neg 10001, not 10010
  - nop 11010, halt 11011
  - everything else is illegal.
- Binary:
  - T3: Grb, Rout, Yin
  - T4: Grc, Rout, Zlowin, alu_op=op_q
  - T5: Zlowout, Gra, Rin; done.
- mul/div:
  - T3: Grb, Rout, Yin
  - T4: Grc, Rout, Zlowin, Zhighin, alu_op=op_q
  - T5: Zlowout, LOin
  - T6: Zhighout, HIin; done.
- Unary:
  - T3: Grb, Rout, Zlowin, alu_op=op_q
  - T4: Zlowout, Gra, Rin; done.
- nop: T3 with no strobes; done.
- halt: T3 goes to HALT.
- Illegal: T3 goes to HALT and sets illegal=1.
- HALT: Run=0, all strobes 0. Exited only by Clear.
- Done (last execute step):
  - instr_count += 1, wrapping at 2^CNTW.
  - Next state is IDLE if Stop=1 on that edge, else T0.
  - Halt and illegal instructions are not counted.
- alu_op is 0 outside the cycles listed above.

## Timing
- Clear=1 asynchronously forces:
  - state=IDLE, op_q=0, illegal=0, instr_count=0
  - all strobes 0, alu_op=0, Run=0
- Clear acts immediately, including mid-instruction, with no partial completion.
- First T0 occurs one cycle after Clear deasserts, provided Stop=0.
- Each state lasts one cycle, except T1 (1 + mem_done wait cycles), IDLE and HALT.
- Latency with mem_done=1 throughout T1, counted from entering T0:
  - binary: 6 cycles
  - unary: 5 cycles
  - mul/div: 7 cycles
  - nop: 4 cycles
- Stop is ignored mid-instruction. It affects only the done-cycle transition and IDLE.
- mem_done asserted outside T1 is ignored.
- IR_opcode is sampled only on the T2→T3 edge; later changes do not alter the instruction in flight.
- Run=1 in T0–T6.

## Test plan
- Clear pulse, Stop=0, mem_done=1, IR_opcode=01001 (rol, IR=0x4A920000) → states T0..T5 on consecutive cycles:
  - T3: Grb+Rout+Yin
  - T4: Grc+Rout+Zlowin with alu_op=01001
  - T5: Zlowout+Gra+Rin
  - then instr_count=1 and back to T0.
- mem_done held low 3 cycles in T1 → Read=MDRin=1 for exactly 4 cycles, then T2. Total rol latency 9 cycles.
- IR_opcode=01111 (mul) → T5 asserts Zlowout+LOin, T6 asserts Zhighout+HIin, Zhighin=1 in T4, instr_count increments after T6.
- Stop=1 raised during T3 of an add → add completes, IDLE with Run=0. Stop=0 → T0 next cycle.
- IR_opcode=11011 (halt) → HALT, Run=0, instr_count unchanged. IR_opcode=11111 → HALT with illegal=1. Both held until Clear.
- Clear asserted mid-T4 → all outputs 0 in the same cycle (asynchronous), instr_count=0, and after release a new fetch begins at T0.

Source files
------------

// File: rtl/alu_seq_control_if.sv
// Control bundle between the Mini SRC sequencer and its datapath.
// mem_done is a completion flag, not a handshake: it matters only while the sequencer sits in T1.
interface alu_seq_control_if #(
    parameter int OPW  = 5,
    parameter int CNTW = 16
);
    logic            Stop;
    logic            mem_done;
    logic [OPW-1:0]  IR_opcode;
    logic            PCout, MARin, IncPC, Read, MDRin, MDRout, IRin;
    logic            Gra, Grb, Grc, Rin, Rout;
    logic            Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin;
    logic [OPW-1:0]  alu_op;
    logic            Run;
    logic            illegal;
    logic [CNTW-1:0] instr_count;

    modport master (
        input  Stop, mem_done, IR_opcode,
        output PCout, MARin, IncPC, Read, MDRin, MDRout, IRin,
               Gra, Grb, Grc, Rin, Rout,
               Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin,
               alu_op, Run, illegal, instr_count
    );

    modport slave (
        output Stop, mem_done, IR_opcode,
        input  PCout, MARin, IncPC, Read, MDRin, MDRout, IRin,
               Gra, Grb, Grc, Rin, Rout,
               Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin,
               alu_op, Run, illegal, instr_count
    );
endinterface

// File: rtl/alu_seq_control.sv
// Hard-wired fetch/execute sequencer for ALU-class Mini SRC instructions.
// Moore outputs decoded from the state register and the latched opcode.
module alu_seq_control #(
    parameter int OPW  = 5,
    parameter int CNTW = 16
) (
    input  logic               Clock,
    input  logic               Clear,
    alu_seq_control_if.master  bus,
    output logic [3:0]         state_dbg
);
    typedef enum logic [3:0] {
        S_IDLE = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
        S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_HALT = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        C_BIN, C_MD, C_UN, C_NOP, C_HALT, C_ILL
    } cls_t;

    state_t          state, state_n;
    cls_t            cls;
    logic [OPW-1:0]  op_q;
    logic            illegal_q;
    logic [CNTW-1:0] count_q;
    logic            done;

    assign state_dbg       = state;
    assign bus.illegal     = illegal_q;
    assign bus.instr_count = count_q;

    always_comb begin
        cls = C_ILL;
        case (op_q)
            5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
            5'b01000, 5'b01001, 5'b01010, 5'b01011: cls = C_BIN;
            5'b01111, 5'b10000:                     cls = C_MD;
            5'b10001, 5'b10010:                     cls = C_UN;
            5'b11010:                               cls = C_NOP;
            5'b11011:                               cls = C_HALT;
            default:                                cls = C_ILL;
        endcase
    end

    always_comb begin
        state_n      = state;
        done         = 1'b0;
        bus.Run      = 1'b0;
        bus.PCout    = 1'b0; bus.MARin    = 1'b0; bus.IncPC   = 1'b0;
        bus.Read     = 1'b0; bus.MDRin    = 1'b0; bus.MDRout  = 1'b0; bus.IRin = 1'b0;
        bus.Gra      = 1'b0; bus.Grb      = 1'b0; bus.Grc     = 1'b0;
        bus.Rin      = 1'b0; bus.Rout     = 1'b0;
        bus.Yin      = 1'b0; bus.Zlowin   = 1'b0; bus.Zhighin = 1'b0;
        bus.Zlowout  = 1'b0; bus.Zhighout = 1'b0; bus.HIin    = 1'b0; bus.LOin = 1'b0;
        bus.alu_op   = '0;
        case (state)
            S_IDLE: if (!bus.Stop) state_n = S_T0;
            S_T0: begin
                bus.Run = 1'b1; bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1;
                state_n = S_T1;
            end
            S_T1: begin
                bus.Run = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1;
                if (bus.mem_done) state_n = S_T2;
            end
            S_T2: begin
                bus.Run = 1'b1; bus.MDRout = 1'b1; bus.IRin = 1'b1;
                state_n = S_T3;
            end
            S_T3: begin
                bus.Run = 1'b1;
                case (cls)
                    C_BIN, C_MD: begin
                        bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
                        state_n = S_T4;
                    end
                    C_UN: begin
                        bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zlowin = 1'b1;
                        bus.alu_op = op_q;
                        state_n = S_T4;
                    end
                    C_NOP:   done = 1'b1;
                    default: state_n = S_HALT;
                endcase
            end
            S_T4: begin
                bus.Run = 1'b1;
                case (cls)
                    C_BIN, C_MD: begin
                        bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zlowin = 1'b1;
                        bus.Zhighin = (cls == C_MD);
                        bus.alu_op = op_q;
                        state_n = S_T5;
                    end
                    C_UN: begin
                        bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
                        done = 1'b1;
                    end
                    default: state_n = S_HALT;
                endcase
            end
            S_T5: begin
                bus.Run = 1'b1;
                case (cls)
                    C_BIN: begin
                        bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
                        done = 1'b1;
                    end
                    C_MD: begin
                        bus.Zlowout = 1'b1; bus.LOin = 1'b1;
                        state_n = S_T6;
                    end
                    default: state_n = S_HALT;
                endcase
            end
            S_T6: begin
                bus.Run = 1'b1;
                if (cls == C_MD) begin
                    bus.Zhighout = 1'b1; bus.HIin = 1'b1;
                    done = 1'b1;
                end else begin
                    state_n = S_HALT;
                end
            end
            S_HALT:  state_n = S_HALT;
            default: state_n = S_IDLE;
        endcase
        // Stop is honoured only at the instruction boundary.
        if (done) state_n = bus.Stop ? S_IDLE : S_T0;
    end

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state     <= S_IDLE;
            op_q      <= '0;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state <= state_n;
            if (state == S_T2) op_q <= bus.IR_opcode;
            if (state == S_T3 && cls == C_ILL) illegal_q <= 1'b1;
            if (done) count_q <= count_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_alu_seq_control.sv
// Directed, table-driven bench for alu_seq_control with hand-written corner sequences.
module tb_alu_seq_control;
  localparam logic [3:0] ST_IDLE = 4'd0, ST_T0 = 4'd1, ST_T1 = 4'd2, ST_T2 = 4'd3,
                         ST_T3 = 4'd4, ST_HALT = 4'd8;

  // Observed word: {alu_op[4:0], PCout..LOin}
  localparam logic [23:0] PCOUT = 24'd1 << 18, MARIN = 24'd1 << 17, INCPC = 24'd1 << 16,
                          READ = 24'd1 << 15, MDRIN = 24'd1 << 14, MDROUT = 24'd1 << 13,
                          IRIN = 24'd1 << 12, GRA = 24'd1 << 11, GRB = 24'd1 << 10,
                          GRC = 24'd1 << 9, RIN = 24'd1 << 8, ROUT = 24'd1 << 7,
                          YIN = 24'd1 << 6, ZLOWIN = 24'd1 << 5, ZHIGHIN = 24'd1 << 4,
                          ZLOWOUT = 24'd1 << 3, ZHIGHOUT = 24'd1 << 2, HIIN = 24'd1 << 1,
                          LOIN = 24'd1;
  localparam logic [23:0] T0_W = PCOUT | MARIN | INCPC;
  localparam logic [23:0] T1_W = READ | MDRIN;
  localparam logic [23:0] T2_W = MDROUT | IRIN;

  typedef struct packed {
    logic [4:0]       op;
    logic [3:0]       waits;
    logic [4:0]       lat;
    logic [2:0]       nsteps;
    logic [3:0][23:0] step;
  } vec_t;

  logic        Clock = 1'b0;
  logic        Clear = 1'b1;
  logic [3:0]  state_dbg;
  logic [23:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          exp_count = 0;
  vec_t        vecs[10];

  alu_seq_control_if #(.OPW(5), .CNTW(16)) bus();

  alu_seq_control #(.OPW(5), .CNTW(16)) dut (
    .Clock(Clock),
    .Clear(Clear),
    .bus(bus),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [23:0] obs();
    return {bus.alu_op, bus.PCout, bus.MARin, bus.IncPC, bus.Read, bus.MDRin, bus.MDRout,
            bus.IRin, bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.Yin, bus.Zlowin,
            bus.Zhighin, bus.Zlowout, bus.Zhighout, bus.HIin, bus.LOin};
  endfunction

  function automatic logic [23:0] aluw(input logic [4:0] op);
    return {op, 19'd0};
  endfunction

  function automatic vec_t mk(input logic [4:0] op, input int waits, input int lat,
                              input int n, input logic [23:0] s0, input logic [23:0] s1,
                              input logic [23:0] s2, input logic [23:0] s3);
    vec_t v;
    v.op = op; v.waits = 4'(waits); v.lat = 5'(lat); v.nsteps = 3'(n);
    v.step[0] = s0; v.step[1] = s1; v.step[2] = s2; v.step[3] = s3;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string nm);
    chk({nm, " strobes"}, 32'(obs()), 32'd0);
    chk({nm, " Run"}, 32'(bus.Run), 32'd0);
  endtask

  // driver: one full instruction starting with the DUT sampled in T0
  task automatic run_instr(input vec_t v, input bit stop_t3, input logic [3:0] end_st,
                           input string nm);
    int cyc = 0;
    chk({nm, " T0 state"}, 32'(state_dbg), 32'(ST_T0));
    chk({nm, " T0 strobes"}, 32'(obs()), 32'(T0_W));
    chk({nm, " T0 Run"}, 32'(bus.Run), 32'd1);
    bus.mem_done = 1'b1;
    tick(); cyc++;
    for (int i = 0; i <= int'(v.waits); i++) begin
      bus.mem_done = (i == int'(v.waits));
      chk({nm, " T1 state"}, 32'(state_dbg), 32'(ST_T1));
      chk({nm, " T1 strobes"}, 32'(obs()), 32'(T1_W));
      tick(); cyc++;
    end
    chk({nm, " T2 state"}, 32'(state_dbg), 32'(ST_T2));
    chk({nm, " T2 strobes"}, 32'(obs()), 32'(T2_W));
    bus.IR_opcode = v.op;
    tick(); cyc++;
    bus.IR_opcode = 5'b11111;
    for (int s = 0; s < int'(v.nsteps); s++) exp_q.push_back(v.step[s]);
    for (int s = 0; s < int'(v.nsteps); s++) begin
      logic [23:0] e;
      if (stop_t3 && s == 0) bus.Stop = 1'b1;
      e = exp_q.pop_front();
      chk({nm, " exec state"}, 32'(state_dbg), 32'(ST_T3) + 32'(s));
      chk({nm, " exec strobes"}, 32'(obs()), 32'(e));
      chk({nm, " exec Run"}, 32'(bus.Run), 32'd1);
      tick(); cyc++;
    end
    chk({nm, " end state"}, 32'(state_dbg), 32'(end_st));
    chk({nm, " latency"}, 32'(cyc), 32'(v.lat));
    if (end_st != ST_HALT) exp_count++;
    chk({nm, " instr_count"}, 32'(bus.instr_count), 32'(exp_count));
  endtask

  task automatic do_clear();
    Clear = 1'b1;
    #1;
    exp_count = 0;
    chk("clear state", 32'(state_dbg), 32'(ST_IDLE));
    chk("clear illegal", 32'(bus.illegal), 32'd0);
    chk("clear count", 32'(bus.instr_count), 32'd0);
    check_idle_outputs("clear");
    @(posedge Clock); #1;
    Clear = 1'b0;
    tick();
    chk("post-clear T0", 32'(state_dbg), 32'(ST_T0));
  endtask

  initial begin
    vec_t bin_rol, add_v, halt_v, ill_v, nop_v;
    bus.Stop = 1'b0; bus.mem_done = 1'b0; bus.IR_opcode = 5'd0;

    vecs[0] = mk(5'b01001, 0, 6, 3, GRB|ROUT|YIN, aluw(5'b01001)|GRC|ROUT|ZLOWIN, ZLOWOUT|GRA|RIN, 24'd0);
    vecs[1] = mk(5'b01001, 3, 9, 3, GRB|ROUT|YIN, aluw(5'b01001)|GRC|ROUT|ZLOWIN, ZLOWOUT|GRA|RIN, 24'd0);
    vecs[2] = mk(5'b00011, 1, 7, 3, GRB|ROUT|YIN, aluw(5'b00011)|GRC|ROUT|ZLOWIN, ZLOWOUT|GRA|RIN, 24'd0);
    vecs[3] = mk(5'b01111, 0, 7, 4, GRB|ROUT|YIN, aluw(5'b01111)|GRC|ROUT|ZLOWIN|ZHIGHIN, ZLOWOUT|LOIN, ZHIGHOUT|HIIN);
    vecs[4] = mk(5'b10000, 2, 9, 4, GRB|ROUT|YIN, aluw(5'b10000)|GRC|ROUT|ZLOWIN|ZHIGHIN, ZLOWOUT|LOIN, ZHIGHOUT|HIIN);
    vecs[5] = mk(5'b10001, 0, 5, 2, aluw(5'b10001)|GRB|ROUT|ZLOWIN, ZLOWOUT|GRA|RIN, 24'd0, 24'd0);
    vecs[6] = mk(5'b10010, 1, 6, 2, aluw(5'b10010)|GRB|ROUT|ZLOWIN, ZLOWOUT|GRA|RIN, 24'd0, 24'd0);
    vecs[7] = mk(5'b11010, 0, 4, 1, 24'd0, 24'd0, 24'd0, 24'd0);
    vecs[8] = mk(5'b00100, 0, 6, 3, GRB|ROUT|YIN, aluw(5'b00100)|GRC|ROUT|ZLOWIN, ZLOWOUT|GRA|RIN, 24'd0);
    vecs[9] = mk(5'b01011, 2, 8, 3, GRB|ROUT|YIN, aluw(5'b01011)|GRC|ROUT|ZLOWIN, ZLOWOUT|GRA|RIN, 24'd0);
    bin_rol = vecs[0];
    add_v   = mk(5'b00011, 0, 6, 3, GRB|ROUT|YIN, aluw(5'b00011)|GRC|ROUT|ZLOWIN, ZLOWOUT|GRA|RIN, 24'd0);
    halt_v  = mk(5'b11011, 0, 4, 1, 24'd0, 24'd0, 24'd0, 24'd0);
    ill_v   = mk(5'b11111, 0, 4, 1, 24'd0, 24'd0, 24'd0, 24'd0);
    nop_v   = vecs[7];

    // reset state
    tick(); tick();
    chk("reset state", 32'(state_dbg), 32'(ST_IDLE));
    chk("reset count", 32'(bus.instr_count), 32'd0);
    chk("reset illegal", 32'(bus.illegal), 32'd0);
    check_idle_outputs("reset");
    Clear = 1'b0;
    tick();

    // table of back-to-back instructions
    for (int k = 0; k < 10; k++) run_instr(vecs[k], 1'b0, ST_T0, $sformatf("vec%0d", k));

    // Stop raised in T3 of an add: completes, parks in IDLE
    run_instr(add_v, 1'b1, ST_IDLE, "stop add");
    check_idle_outputs("stop idle");
    tick();
    chk("stop hold idle", 32'(state_dbg), 32'(ST_IDLE));
    bus.Stop = 1'b0;
    tick();
    chk("resume T0", 32'(state_dbg), 32'(ST_T0));

    // halt: parks in HALT, not counted
    run_instr(halt_v, 1'b0, ST_HALT, "halt");
    for (int i = 0; i < 3; i++) tick();
    chk("halt hold", 32'(state_dbg), 32'(ST_HALT));
    chk("halt illegal", 32'(bus.illegal), 32'd0);
    check_idle_outputs("halt");
    do_clear();

    // illegal opcode: HALT with sticky illegal
    run_instr(ill_v, 1'b0, ST_HALT, "illegal");
    tick(); tick();
    chk("illegal hold", 32'(state_dbg), 32'(ST_HALT));
    chk("illegal flag", 32'(bus.illegal), 32'd1);
    check_idle_outputs("illegal halt");
    do_clear();

    // Clear mid-T4 of a mul after one counted nop
    run_instr(nop_v, 1'b0, ST_T0, "pre nop");
    bus.mem_done = 1'b1;
    tick(); tick();
    bus.IR_opcode = 5'b01111;
    tick(); tick();
    chk("mid T4 strobes", 32'(obs()), 32'(aluw(5'b01111)|GRC|ROUT|ZLOWIN|ZHIGHIN));
    #2;
    do_clear();

    // fresh fetch after clear
    run_instr(bin_rol, 1'b0, ST_T0, "post clear rol");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
